seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Runtime-programmable, parametrised serial sequence detector; the next-generation replacement for the fixed-pattern Mealy detectors in the FPGA lab designs. Samples one serial bit per enabled clock. Matches it against a loaded pattern of 1..MAX_W bits, in overlapping or non-overlapping mode. Provides a combinational Mealy match, a registered copy and a saturating match counter.

## Interface
- MAX_W, default 8: maximum pattern length in bits (≥ 2).
- CNT_W, default 8: match counter width.
- LEN_W, derived as $clog2(MAX_W+1): width of the length field.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk externally).
- en  in  1  sample strobe; x is consumed on a clk edge only when en=1.
- x  in  1  serial data bit.
- cfg_load  in  1  latches cfg_pattern, cfg_len and cfg_overlap on this edge.
- cfg_pattern  in  MAX_W  pattern; bit[len-1] is the first bit received and bit[0] is the last.
- cfg_len  in  LEN_W  pattern length; 0 disables the detector; values > MAX_W clamp to MAX_W.
- cfg_overlap  in  1  1 = overlapping matches, 0 = history discarded after each match.
- count_clr  in  1  synchronous clear of match_count.
- z  out  1  Mealy match: combinational from current x and state.
- z_q  out  1  z registered on accepted samples; otherwise 0 on the following cycle.
- armed  out  1  state == ARMED.
- match_count  out  CNT_W  saturating count of accepted matches.

## Operation
- Latched config: pat_q, len_q, ovl_q. Reset values are 0, 0 and 1.
- hist[MAX_W-2:0] holds previous accepted bits, with the newest in bit 0. fill counts valid history bits and saturates at MAX_W-1.
- match = en & ~cfg_load & (len_q != 0) & (fill >= len_q-1) & ({hist[len_q-2:0], x} == pat_q[len_q-1:0]).
- When len_q = 1, match = (x == pat_q[0]) and history is unused.
- z = match.
- States (package enum):
  - IDLE: len_q = 0.
  - FILL: fill < len_q-1.
  - ARMED: fill ≥ len_q-1.
- On an accepted sample (en=1, cfg_load=0):
  - hist shifts left with x inserted at bit 0.
  - If match and ovl_q=0, fill goes to 0.
  - Otherwise fill increments, saturating.
- Transitions:
  - IDLE→FILL on cfg_load with cfg_len ≠ 0.
  - FILL→ARMED when fill reaches len_q-1.
  - ARMED→FILL on a non-overlap match (len_q > 1).
  - Any state→IDLE on cfg_load with cfg_len = 0.
- cfg_load takes priority over en: it latches config, clears fill and hist, and suppresses z and any count update that cycle.
- match_count increments by 1 on each match and holds at all-ones. If count_clr and match occur on the same edge, the result is 1.
- Reset in mid-operation clears hist, fill, config, z_q and match_count immediately. The detector is then in IDLE and z=0.

## Timing
- z: zero latency, valid in the same cycle as x/en. The driver must hold x stable around the edge.
- z_q and match_count update on the edge that accepts the matching bit, so they are visible 1 cycle after z.
- armed reflects the registered state; there is 1 cycle from fill completion.
- Config takes effect on the first accepted sample after the cfg_load edge. Minimum time to first match after load: len_q accepted samples.
- en=0 cycles are transparent: no shift, no count, z=0.
- Reset values: z=0 (IDLE), z_q=0, armed=0, match_count=0.

## Structure
- Package seqdet_pkg:
  - state enum (IDLE, FILL, ARMED).
  - length-clamp function.
  - default MAX_W/CNT_W constants.
- Sub-module seqdet_sat_counter: CNT_W-wide, with inc, clr and clear-plus-increment-gives-1 rule.
- Top level: config registers, history shift register, fill counter, masked comparator (generate loop over MAX_W) and FSM.

## Test plan
- Overlap: load pattern 1101, len 4, overlap=1; stream 1101101 with en=1. Required: z high on bits 4 and 7, match_count=2.
- Non-overlap: same load with overlap=0 and the same stream. Required: z only on bit 4, match_count=1, armed low on the cycle after bit 4.
- Gaps and short pattern: len=1, pattern 0; stream 0,1,0 with an en=0 cycle between samples. Required: z on each 0 sample only, z=0 during the gap, count=2.
- Reload mid-stream: after bits 110, cfg_load 0b101 len 3 with en=1 on the same cycle. Required: that sample is ignored and z=0; stream 101 gives z on the 3rd bit.
- Saturation and clear: CNT_W=2 with 5 matches. Required: count holds at 3; count_clr together with a match gives 1.
- Reset mid-operation: rst low during ARMED. Required: z, z_q, armed and match_count go to 0 asynchronously; after release with no cfg_load, a stream of 1101 produces no match.

Source files
------------

// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
// Holds the FSM state encoding, default sizes and the length clamp.
package seqdet_pkg;

   localparam int unsigned DEF_MAX_W = 8;
   localparam int unsigned DEF_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      ARMED
   } state_t;

   // Lengths above the pattern capacity behave as a full-width pattern.
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_w);
      return (len > max_w) ? max_w : len;
   endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// Saturating match counter with synchronous clear.
// A clear coinciding with an increment leaves the count at 1.
module seqdet_sat_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= inc ? CNT_W'(1) : '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial sequence detector with Mealy match output,
// registered match copy and saturating match counter.
module seq_detector_param
   import seqdet_pkg::*;
#(
   parameter int unsigned MAX_W = DEF_MAX_W,
   parameter int unsigned CNT_W = DEF_CNT_W,
   parameter int unsigned LEN_W = $clog2(MAX_W + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             x,
   input  logic             cfg_load,
   input  logic [MAX_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic             count_clr,
   output logic             z,
   output logic             z_q,
   output logic             armed,
   output logic [CNT_W-1:0] match_count
);

   localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_W - 1);

   logic [MAX_W-1:0] pat_q;
   logic [LEN_W-1:0] len_q;
   logic             ovl_q;
   logic [MAX_W-2:0] hist, hist_d;
   logic [LEN_W-1:0] fill, fill_d;
   logic [LEN_W-1:0] len_new;
   state_t           state_q, state_d;

   logic [MAX_W-1:0] cand;
   logic [MAX_W-1:0] diff;
   logic             accept;
   logic             ready;
   logic             match;

   assign len_new = LEN_W'(clamp_len(32'(cfg_len), MAX_W));
   assign accept  = en & ~cfg_load;
   assign cand    = {hist, x};

   // Bits at or above len_q never take part in the comparison.
   for (genvar i = 0; i < MAX_W; i++) begin : g_cmp
      localparam logic [LEN_W-1:0] IDX = LEN_W'(i);
      assign diff[i] = (IDX < len_q) & (cand[i] ^ pat_q[i]);
   end

   assign ready = ({1'b0, fill} + (LEN_W+1)'(1)) >= {1'b0, len_q};
   assign match = accept & (len_q != '0) & ready & ~|diff;
   assign z     = match;
   assign armed = (state_q == ARMED);

   always_comb begin
      hist_d = hist;
      fill_d = fill;
      if (cfg_load) begin
         hist_d = '0;
         fill_d = '0;
      end else if (accept) begin
         hist_d = cand[MAX_W-2:0];
         if (match && !ovl_q)
            fill_d = '0;
         else if (fill != FILL_MAX)
            fill_d = fill + LEN_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      if (cfg_load) begin
         if (len_new == '0)
            state_d = IDLE;
         else if (len_new == LEN_W'(1))
            state_d = ARMED;
         else
            state_d = FILL;
      end else if (accept) begin
         case (state_q)
            IDLE:  state_d = IDLE;
            FILL:  if (({1'b0, fill_d} + (LEN_W+1)'(1)) >= {1'b0, len_q})
                      state_d = ARMED;
            ARMED: if (match && !ovl_q && (len_q > LEN_W'(1)))
                      state_d = FILL;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b1;
         hist    <= '0;
         fill    <= '0;
         state_q <= IDLE;
         z_q     <= 1'b0;
      end else begin
         if (cfg_load) begin
            pat_q <= cfg_pattern;
            len_q <= len_new;
            ovl_q <= cfg_overlap;
         end
         hist    <= hist_d;
         fill    <= fill_d;
         state_q <= state_d;
         z_q     <= match;
      end
   end

   seqdet_sat_counter #(
      .CNT_W(CNT_W)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (match),
      .clr  (count_clr),
      .count(match_count)
   );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param; expected z_q values are queued
// when a sample is driven and retired after the accepting edge.
module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       en, x, cfg_load, cfg_overlap, count_clr;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       z, z_q, armed;
   logic [1:0] match_count;

   int   vectors = 0;
   int   miscompares = 0;
   int   exp_cnt = 0;
   logic exp_q[$];

   always #5 clk = ~clk;

   seq_detector_param #(
      .MAX_W(8),
      .CNT_W(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .x          (x),
      .cfg_load   (cfg_load),
      .cfg_pattern(cfg_pattern),
      .cfg_len    (cfg_len),
      .cfg_overlap(cfg_overlap),
      .count_clr  (count_clr),
      .z          (z),
      .z_q        (z_q),
      .armed      (armed),
      .match_count(match_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // One clock of stimulus: z checked before the edge, z_q/count after it.
   task automatic step(input string tag, input logic e, input logic b, input logic ld,
                       input logic clr, input logic exp_z);
      @(negedge clk);
      en = e; x = b; cfg_load = ld; count_clr = clr;
      #2;
      check({tag, "/z"}, {31'd0, z}, {31'd0, exp_z});
      exp_q.push_back(exp_z);
      if (clr)
         exp_cnt = exp_z ? 1 : 0;
      else if (exp_z && exp_cnt != 3)
         exp_cnt++;
      @(posedge clk);
      #1;
      check({tag, "/z_q"}, {31'd0, z_q}, {31'd0, exp_q.pop_front()});
      check({tag, "/count"}, {30'd0, match_count}, exp_cnt);
      en = 1'b0; cfg_load = 1'b0; count_clr = 1'b0;
   endtask

   task automatic load(input string tag, input logic [7:0] pat, input logic [3:0] len,
                       input logic ovl);
      cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
      step(tag, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic clear_count();
      step("clr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; x = 1'b0; cfg_load = 1'b0; count_clr = 1'b0;
      cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
      #12;
      check("rst/z", {31'd0, z}, 0);
      check("rst/z_q", {31'd0, z_q}, 0);
      check("rst/armed", {31'd0, armed}, 0);
      check("rst/count", {30'd0, match_count}, 0);
      @(negedge clk);
      rst = 1'b1;

      // Overlapping 1101 over 1101101
      load("ovl_ld", 8'b1101, 4'd4, 1'b1);
      step("ovl1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("ovl2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("ovl2/armed", {31'd0, armed}, 0);
      step("ovl3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ovl3/armed", {31'd0, armed}, 1);
      step("ovl4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step("ovl5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("ovl6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step("ovl7", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check("ovl/total", {30'd0, match_count}, 2);
      clear_count();

      // Non-overlapping: history dropped after the first match
      load("novl_ld", 8'b1101, 4'd4, 1'b0);
      step("novl1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("novl2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("novl3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step("novl4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check("novl4/armed", {31'd0, armed}, 0);
      step("novl5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("novl6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step("novl7", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("novl/total", {30'd0, match_count}, 1);
      clear_count();

      // Single-bit pattern 0 with en gaps (x held 0 in the gaps)
      load("gap_ld", 8'b0, 4'd1, 1'b1);
      step("gap_s0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step("gap_g0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("gap_s1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("gap_g1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("gap_s2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("gap/total", {30'd0, match_count}, 2);
      clear_count();

      // Reload mid-stream: the sample on the load edge would have matched 1101
      load("rl_ld0", 8'b1101, 4'd4, 1'b1);
      step("rl1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("rl2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("rl3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cfg_pattern = 8'b101; cfg_len = 4'd3; cfg_overlap = 1'b1;
      step("rl_ld1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step("rl4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("rl5", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step("rl6", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check("rl/total", {30'd0, match_count}, 1);
      clear_count();

      // Saturation at 3, then clear together with a match
      load("sat_ld", 8'b1, 4'd1, 1'b1);
      for (int i = 0; i < 5; i++)
         step("sat", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check("sat/hold", {30'd0, match_count}, 3);
      step("sat_clr", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      check("sat/clr_inc", {30'd0, match_count}, 1);
      clear_count();

      // Oversized length clamps to the full 8-bit pattern 10100101
      load("clamp_ld", 8'hA5, 4'd15, 1'b1);
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] p;
         p = 8'hA5;
         step("clamp", 1'b1, p[i], 1'b0, 1'b0, (i == 0) ? 1'b1 : 1'b0);
      end
      clear_count();

      // Asynchronous reset while armed with z_q and count set
      load("rs_ld", 8'b1101, 4'd4, 1'b1);
      step("rs1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("rs2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("rs3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step("rs4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check("rs/armed_pre", {31'd0, armed}, 1);
      @(negedge clk);
      en = 1'b1; x = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("rs/z", {31'd0, z}, 0);
      check("rs/z_q", {31'd0, z_q}, 0);
      check("rs/armed", {31'd0, armed}, 0);
      check("rs/count", {30'd0, match_count}, 0);
      en = 1'b0;
      exp_q.delete();
      exp_cnt = 0;
      @(negedge clk);
      rst = 1'b1;
      step("post1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("post2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("post3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step("post4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("post/armed", {31'd0, armed}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
